// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// alu_issue_stage : serialised issue/writeback stage around an external 8-bit ALU
// Rev 1.0
// ============================================================================
module alu_issue_stage #(
  parameter int         NREGS  = 4,
  parameter logic [2:0] CMP_OP = 3'b111
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_opcode,
  input  logic [1:0] in_dst,
  input  logic [1:0] in_src_a,
  input  logic [1:0] in_src_b,
  input  logic       in_use_imm,
  input  logic [7:0] in_imm,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_opcode,
  input  logic [7:0] alu_result,
  input  logic       alu_zero,
  input  logic       alu_carry,
  input  logic       alu_overflow,
  output logic       wb_valid,
  input  logic       wb_ready,
  output logic [1:0] wb_dst,
  output logic [7:0] wb_data,
  output logic [2:0] flags
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [NREGS-1:1][7:0]   rf_q;
  logic [7:0]              alu_a_q, alu_b_q;
  logic [2:0]              op_q;
  logic [1:0]              dst_q;
  logic [1:0]              wb_dst_q;
  logic [7:0]              wb_data_q;
  logic [2:0]              flags_q;

  logic [7:0]              rd_a, rd_b;
  logic                    accept;
  logic                    is_cmp;
  logic                    do_write;

  // R0 has no storage; any index without a matching entry reads as zero.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int i = 1; i < NREGS; i++) begin
      if (in_src_a == 2'(i)) rd_a = rf_q[i];
      if (in_src_b == 2'(i)) rd_b = rf_q[i];
    end
  end

  assign accept   = (state_q == IDLE) && in_valid;
  assign is_cmp   = (op_q == CMP_OP);
  assign do_write = (state_q == EXEC) && !is_cmp;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = EXEC;
      EXEC:    state_d = is_cmp ? IDLE : WB;
      WB:      if (wb_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rf_q      <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      op_q      <= '0;
      dst_q     <= '0;
      wb_dst_q  <= '0;
      wb_data_q <= '0;
      flags_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        alu_a_q <= rd_a;
        alu_b_q <= in_use_imm ? in_imm : rd_b;
        op_q    <= in_opcode;
        dst_q   <= in_dst;
      end
      if (state_q == EXEC) begin
        flags_q <= {alu_overflow, alu_carry, alu_zero};
      end
      // The register file is written on the same edge that raises wb_valid,
      // so the next accepted instruction always sees the new value.
      if (do_write) begin
        wb_data_q <= alu_result;
        wb_dst_q  <= dst_q;
        for (int i = 1; i < NREGS; i++) begin
          if (dst_q == 2'(i)) rf_q[i] <= alu_result;
        end
      end
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign wb_valid   = (state_q == WB);
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = op_q;
  assign wb_dst     = wb_dst_q;
  assign wb_data    = wb_data_q;
  assign flags      = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
// tb_alu_issue_stage : randomized self-checking bench with a reference model
// Rev 1.0
// ============================================================================
module tb_alu_issue_stage;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_opcode = '0;
  logic [1:0] in_dst = '0, in_src_a = '0, in_src_b = '0;
  logic       in_use_imm = 1'b0;
  logic [7:0] in_imm = '0;
  logic [7:0] alu_a, alu_b;
  logic [2:0] alu_opcode;
  logic [7:0] alu_result;
  logic       alu_zero, alu_carry, alu_overflow;
  logic       wb_valid;
  logic       wb_ready = 1'b0;
  logic [1:0] wb_dst;
  logic [7:0] wb_data;
  logic [2:0] flags;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] m_rf [4];
  logic [2:0] m_flags;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_dst(in_dst), .in_src_a(in_src_a), .in_src_b(in_src_b),
    .in_use_imm(in_use_imm), .in_imm(in_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .alu_overflow(alu_overflow),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_dst(wb_dst),
    .wb_data(wb_data), .flags(flags)
  );

  // Returns {overflow, carry, zero, result}. Ops: ADD SUB AND OR XOR SHL SHR CMP.
  function automatic logic [10:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int s;
    logic [7:0] r;
    logic c, v;
    s = 0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      3'd0: begin
        s = int'(a) + int'(b); r = 8'(s); c = (s > 255);
        v = (a[7] == b[7]) && (r[7] != a[7]);
      end
      3'd1, 3'd7: begin
        s = int'(a) - int'(b); r = 8'(s); c = (s < 0);
        v = (a[7] != b[7]) && (r[7] != a[7]);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = a << b[2:0];
      default: r = a >> b[2:0];
    endcase
    return {v, c, (r == 8'h00), r};
  endfunction

  always_comb {alu_overflow, alu_carry, alu_zero, alu_result} = alu_f(alu_opcode, alu_a, alu_b);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic issue(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] sa,
                       input logic [1:0] sb, input logic ui, input logic [7:0] imm, input int stall);
    logic [7:0]  a, b;
    logic [10:0] r;
    a = (sa == 2'd0) ? 8'h00 : m_rf[sa];
    b = ui ? imm : ((sb == 2'd0) ? 8'h00 : m_rf[sb]);
    r = alu_f(op, a, b);
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; in_opcode = op; in_dst = dst; in_src_a = sa; in_src_b = sb;
    in_use_imm = ui; in_imm = imm;
    @(negedge clk);
    in_valid = 1'b0;
    chk("alu_a", alu_a, a);
    chk("alu_b", alu_b, b);
    chk("alu_opcode", alu_opcode, op);
    chk("in_ready_exec", in_ready, 0);
    chk("wb_valid_exec", wb_valid, 0);
    m_flags = r[10:8];
    if (op != 3'd7 && dst != 2'd0) m_rf[dst] = r[7:0];
    @(negedge clk);
    chk("flags", flags, m_flags);
    if (op == 3'd7) begin
      chk("wb_valid_cmp", wb_valid, 0);
      chk("in_ready_cmp", in_ready, 1);
    end else begin
      chk("wb_valid", wb_valid, 1);
      chk("wb_dst", wb_dst, dst);
      chk("wb_data", wb_data, r[7:0]);
      chk("in_ready_wb", in_ready, 0);
      for (int k = 0; k < stall; k++) begin
        in_valid = 1'b1; in_opcode = 3'($urandom); in_dst = 2'($urandom);
        in_imm = 8'($urandom); in_use_imm = 1'b1;
        @(negedge clk);
        chk("wb_valid_hold", wb_valid, 1);
        chk("wb_dst_hold", wb_dst, dst);
        chk("wb_data_hold", wb_data, r[7:0]);
        chk("in_ready_hold", in_ready, 0);
      end
      in_valid = 1'b0;
      wb_ready = 1'b1;
      @(negedge clk);
      wb_ready = 1'b0;
      chk("wb_valid_done", wb_valid, 0);
      chk("in_ready_done", in_ready, 1);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_wb_valid"}, wb_valid, 0);
    chk({tag, "_wb_dst"}, wb_dst, 0);
    chk({tag, "_wb_data"}, wb_data, 0);
    chk({tag, "_flags"}, flags, 0);
    chk({tag, "_alu_a"}, alu_a, 0);
    chk({tag, "_alu_b"}, alu_b, 0);
    chk({tag, "_alu_opcode"}, alu_opcode, 0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
    m_flags = 3'b000;
    #2;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    issue(3'd0, 2'd1, 2'd0, 2'd0, 1'b1, 8'h05, 0);
    issue(3'd0, 2'd2, 2'd0, 2'd0, 1'b1, 8'hFF, 0);
    issue(3'd0, 2'd3, 2'd1, 2'd2, 1'b0, 8'h00, 0);
    issue(3'd0, 2'd1, 2'd0, 2'd0, 1'b1, 8'h7F, 0);
    issue(3'd0, 2'd1, 2'd1, 2'd0, 1'b1, 8'h01, 0);
    issue(3'd7, 2'd3, 2'd3, 2'd0, 1'b1, 8'h04, 0);
    issue(3'd0, 2'd0, 2'd3, 2'd0, 1'b1, 8'h00, 0);
    issue(3'd2, 2'd2, 2'd2, 2'd3, 1'b0, 8'h00, 3);
    issue(3'd0, 2'd0, 2'd0, 2'd0, 1'b1, 8'h33, 1);
    issue(3'd3, 2'd1, 2'd0, 2'd0, 1'b1, 8'h00, 0);

    for (int n = 0; n < 60; n++) begin
      issue(3'($urandom_range(0, 7)), 2'($urandom), 2'($urandom), 2'($urandom),
            1'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
    end

    @(negedge clk);
    in_valid = 1'b1; in_opcode = 3'd0; in_dst = 2'd1; in_src_a = 2'd0;
    in_use_imm = 1'b1; in_imm = 8'h5A;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_exec");
    for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
    m_flags = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i < 4; i++) issue(3'd0, 2'd0, 2'(i), 2'd0, 1'b1, 8'h00, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
